// File: rtl/LDPC_pkg.sv
// Shared LDPC types and constants: base-graph selector, parity block counts,
// parity word width and the parity readout FSM state encoding.
package LDPC_pkg;

  localparam int unsigned MAX_ZC            = 384;
  localparam int unsigned ZC_W              = 9;
  localparam int unsigned BG1_PARITY_BLOCKS = 46;
  localparam int unsigned BG2_PARITY_BLOCKS = 42;

  typedef enum logic {
    BG1 = 1'b0,
    BG2 = 1'b1
  } bg_t;

  typedef enum logic [1:0] {
    PR_IDLE  = 2'd0,
    PR_READ  = 2'd1,
    PR_DRAIN = 2'd2
  } pr_state_t;

endpackage

// File: rtl/ldpc_pb_skid_fifo.sv
// Two-entry skid FIFO for parity beats. The head entry is a register so the
// output stream is driven straight from flops.
// Ports: clk, rst_n (async active-low), push/din (write), pop (read),
//        dout (head entry), full, empty, count (0..2).
module ldpc_pb_skid_fifo #(
  parameter int unsigned W = LDPC_pkg::MAX_ZC + 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign count   = cnt;
  assign dout    = head;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Entry shift structure: tail moves into head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= tail;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ldpc_parity_readout.sv
// Drains finished LDPC parity blocks from the encoder parity memory and emits
// them as a valid/ready stream of Zc-wide beats, truncating the final beat so
// exactly e_parity bits leave the block.
// Ports: clk, reset_n (async active-low);
//        cw_vector_valid/bg/zc/e_parity : job start (rising edge) and job parameters;
//        parity_out_address/parity_out_rd_en/parity_out : parity memory read port (1-cycle latency);
//        pb_data/pb_len/pb_valid/pb_last/pb_ready : output beat stream;
//        busy : job in progress; done : one-cycle pulse after the last beat is accepted.
module ldpc_parity_readout #(
  parameter int unsigned MAX_ZC            = LDPC_pkg::MAX_ZC,
  parameter int unsigned ADDR_W            = 9,
  parameter int unsigned E_W               = 16,
  parameter int unsigned BG1_PARITY_BLOCKS = LDPC_pkg::BG1_PARITY_BLOCKS,
  parameter int unsigned BG2_PARITY_BLOCKS = LDPC_pkg::BG2_PARITY_BLOCKS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cw_vector_valid,
  input  LDPC_pkg::bg_t               bg,
  input  logic [LDPC_pkg::ZC_W-1:0]   zc,
  input  logic [E_W-1:0]              e_parity,
  output logic [ADDR_W-1:0]           parity_out_address,
  output logic                        parity_out_rd_en,
  input  logic [MAX_ZC-1:0]           parity_out,
  output logic [MAX_ZC-1:0]           pb_data,
  output logic [LDPC_pkg::ZC_W-1:0]   pb_len,
  output logic                        pb_valid,
  output logic                        pb_last,
  input  logic                        pb_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned ZC_W = LDPC_pkg::ZC_W;
  localparam int unsigned FW   = MAX_ZC + ZC_W + 1;

  LDPC_pkg::pr_state_t state;
  LDPC_pkg::pr_state_t state_nxt;

  logic              cvv_q;
  logic              start_edge;
  logic [ZC_W-1:0]   zc_q;
  logic [ADDR_W-1:0] blk_max_q;
  logic [ADDR_W-1:0] rd_idx;
  logic [E_W-1:0]    rd_rem;
  logic              rd_q;
  logic [ZC_W-1:0]   tag_len;
  logic              tag_last;
  logic              done_q;

  logic              rd_issue;
  logic              done_nxt;
  logic              job_start;
  logic [ZC_W-1:0]   rd_len;
  logic              rd_last;
  logic              pop;
  logic              credit_ok;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [MAX_ZC-1:0] data_masked;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;

  assign start_edge = cw_vector_valid & ~cvv_q;
  assign pop        = pb_valid & pb_ready;

  // Tag of the read about to be issued: length never exceeds remaining budget.
  assign rd_len  = (rd_rem < E_W'(zc_q)) ? ZC_W'(rd_rem) : zc_q;
  assign rd_last = (rd_rem <= E_W'(zc_q)) || (rd_idx == blk_max_q - ADDR_W'(1));

  // A new read lands one cycle later; it may only go out if the FIFO can hold
  // it counting the read already in flight and any pop happening right now.
  assign credit_ok = fifo_full ? (pop & ~rd_q)
                               : ((3'(fifo_count) + 3'(rd_q)) <= (pop ? 3'd2 : 3'd1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LDPC_pkg::PR_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    done_nxt  = 1'b0;
    job_start = 1'b0;
    case (state)
      LDPC_pkg::PR_IDLE: begin
        if (start_edge) begin
          if (e_parity == '0 || zc == '0) begin
            done_nxt = 1'b1;
          end else begin
            job_start = 1'b1;
            state_nxt = LDPC_pkg::PR_READ;
          end
        end
      end
      LDPC_pkg::PR_READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          if (rd_last) state_nxt = LDPC_pkg::PR_DRAIN;
        end
      end
      LDPC_pkg::PR_DRAIN: begin
        // The last-tagged beat is the only entry left once it reaches the head.
        if (pop && pb_last) begin
          done_nxt  = 1'b1;
          state_nxt = LDPC_pkg::PR_IDLE;
        end
      end
      default: state_nxt = LDPC_pkg::PR_IDLE;
    endcase
  end

  // Job parameters, read counters and the tag travelling with each read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cvv_q     <= 1'b0;
      zc_q      <= '0;
      blk_max_q <= '0;
      rd_idx    <= '0;
      rd_rem    <= '0;
      rd_q      <= 1'b0;
      tag_len   <= '0;
      tag_last  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cvv_q  <= cw_vector_valid;
      rd_q   <= rd_issue;
      done_q <= done_nxt;
      if (job_start) begin
        zc_q      <= zc;
        blk_max_q <= (bg == LDPC_pkg::BG1) ? ADDR_W'(BG1_PARITY_BLOCKS)
                                           : ADDR_W'(BG2_PARITY_BLOCKS);
        rd_idx    <= '0;
        rd_rem    <= e_parity;
      end else if (rd_issue) begin
        rd_idx <= rd_idx + ADDR_W'(1);
        rd_rem <= rd_rem - E_W'(rd_len);
      end
      if (rd_issue) begin
        tag_len  <= rd_len;
        tag_last <= rd_last;
      end
    end
  end

  // Zero every bit at or above the beat length before it is stored.
  for (genvar g = 0; g < int'(MAX_ZC); g++) begin : g_mask
    assign data_masked[g] = parity_out[g] & (ZC_W'(g) < tag_len);
  end

  assign fifo_din = {tag_last, tag_len, data_masked};

  ldpc_pb_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (rd_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign parity_out_address = rd_idx;
  assign parity_out_rd_en   = rd_issue;
  assign pb_data            = fifo_dout[MAX_ZC-1:0];
  assign pb_len             = fifo_dout[MAX_ZC +: ZC_W];
  assign pb_last            = fifo_dout[FW-1];
  assign pb_valid           = ~fifo_empty;
  assign busy               = (state != LDPC_pkg::PR_IDLE);
  assign done               = done_q;

endmodule

// File: tb/tb_ldpc_parity_readout.sv
// Scoreboard bench for ldpc_parity_readout: directed jobs push expected reads
// and beats into queues; a monitor compares every read and accepted beat.
module tb_ldpc_parity_readout;

  localparam int CW = 384;

  logic                clk;
  logic                reset_n;
  logic                cw_vector_valid;
  LDPC_pkg::bg_t       bg;
  logic [8:0]          zc;
  logic [15:0]         e_parity;
  logic [8:0]          parity_out_address;
  logic                parity_out_rd_en;
  logic [CW-1:0]       parity_out;
  logic [CW-1:0]       pb_data;
  logic [8:0]          pb_len;
  logic                pb_valid;
  logic                pb_last;
  logic                pb_ready;
  logic                busy;
  logic                done;

  typedef struct {
    int unsigned addr;
    int unsigned len;
    bit          last;
  } beat_t;

  beat_t       beat_q[$];
  int unsigned addr_q[$];
  int          total = 0;
  int          bad = 0;
  int          acc_count = 0;
  bit          last_acc_q = 1'b0;
  bit          zero_job = 1'b0;
  int          pat_mode = 0;
  int          ready_mode = 0;

  ldpc_parity_readout dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cw_vector_valid    (cw_vector_valid),
    .bg                 (bg),
    .zc                 (zc),
    .e_parity           (e_parity),
    .parity_out_address (parity_out_address),
    .parity_out_rd_en   (parity_out_rd_en),
    .parity_out         (parity_out),
    .pb_data            (pb_data),
    .pb_len             (pb_len),
    .pb_valid           (pb_valid),
    .pb_last            (pb_last),
    .pb_ready           (pb_ready),
    .busy               (busy),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] pattern(input int unsigned a, input int mode);
    logic [31:0] w;
    logic [7:0]  b;
    if (mode == 1) return '1;
    b = a[7:0];
    w = {b, 8'hA5, ~b, 8'h3C};
    return {12{w}};
  endfunction

  function automatic logic [CW-1:0] mask_of(input int unsigned len);
    logic [CW-1:0] m;
    for (int unsigned i = 0; i < CW; i++) m[i] = (i < len);
    return m;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Encoder parity memory model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (parity_out_rd_en) parity_out <= pattern(32'(parity_out_address), pat_mode);
  end

  // Downstream ready generator.
  initial begin
    pb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       pb_ready = ~pb_ready;
        2:       pb_ready = 1'($urandom_range(0, 1));
        default: pb_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks read addresses, accepted beats and done timing.
  always @(negedge clk) begin
    beat_t       eb;
    int unsigned ea;
    if (reset_n) begin
      if (parity_out_rd_en) begin
        if (addr_q.size() == 0) begin
          fail("unexpected_read");
        end else begin
          ea = addr_q.pop_front();
          chk("rd_addr", CW'(parity_out_address), CW'(ea));
        end
      end
      if (!zero_job && (done || last_acc_q)) chk("done_timing", CW'(done), CW'(last_acc_q));
      last_acc_q = pb_valid && pb_ready && pb_last;
      if (pb_valid && pb_ready) begin
        acc_count++;
        if (beat_q.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          eb = beat_q.pop_front();
          chk("pb_len", CW'(pb_len), CW'(eb.len));
          chk("pb_last", CW'(pb_last), CW'(eb.last));
          chk("pb_data", pb_data, pattern(eb.addr, pat_mode) & mask_of(eb.len));
        end
      end
    end
  end

  task automatic exp_beat(input int unsigned a, input int unsigned len, input bit last);
    beat_t b;
    b.addr = a;
    b.len  = len;
    b.last = last;
    beat_q.push_back(b);
    addr_q.push_back(a);
  endtask

  // Returns #1 into the cycle whose closing edge samples the start edge.
  task automatic start_job(input LDPC_pkg::bg_t b, input int unsigned z, input int unsigned e);
    @(posedge clk);
    #1;
    cw_vector_valid = 1'b0;
    bg              = b;
    zc              = 9'(z);
    e_parity        = 16'(e);
    @(posedge clk);
    #1;
    cw_vector_valid = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail({name, "_done_timeout"});
    else           chk({name, "_busy_at_done"}, CW'(busy), CW'(0));
    chk({name, "_beats_left"}, CW'(beat_q.size()), CW'(0));
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_rd_en"},   CW'(parity_out_rd_en),   CW'(0));
    chk({name, "_addr"},    CW'(parity_out_address), CW'(0));
    chk({name, "_valid"},   CW'(pb_valid),           CW'(0));
    chk({name, "_last"},    CW'(pb_last),            CW'(0));
    chk({name, "_len"},     CW'(pb_len),             CW'(0));
    chk({name, "_data"},    pb_data,                 CW'(0));
    chk({name, "_busy"},    CW'(busy),               CW'(0));
    chk({name, "_done"},    CW'(done),               CW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    reset_n         = 1'b0;
    cw_vector_valid = 1'b0;
    bg              = LDPC_pkg::BG1;
    zc              = 9'd0;
    e_parity        = 16'd0;
    parity_out      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // BG1, zc=384, e=1000: 384,384,232; latency and ignored second edge.
    pat_mode   = 0;
    ready_mode = 0;
    exp_beat(0, 384, 1'b0);
    exp_beat(1, 384, 1'b0);
    exp_beat(2, 232, 1'b1);
    start_job(LDPC_pkg::BG1, 384, 1000);
    @(negedge clk);
    chk("t1_rd_en_T", CW'(parity_out_rd_en), CW'(0));
    @(negedge clk);
    chk("t1_rd_en_T1", CW'(parity_out_rd_en), CW'(1));
    chk("t1_busy_T1", CW'(busy), CW'(1));
    @(negedge clk);
    chk("t1_valid_T2", CW'(pb_valid), CW'(0));
    @(negedge clk);
    chk("t1_valid_T3", CW'(pb_valid), CW'(1));
    cw_vector_valid = 1'b0;
    @(negedge clk);
    cw_vector_valid = 1'b1;
    wait_done("t1");
    repeat (4) @(negedge clk);
    chk("t1_idle_after", CW'(busy), CW'(0));

    // Masking: all-ones parity, final beat truncated to 232 bits.
    pat_mode = 1;
    exp_beat(0, 384, 1'b0);
    exp_beat(1, 384, 1'b0);
    exp_beat(2, 232, 1'b1);
    start_job(LDPC_pkg::BG1, 384, 1000);
    wait_done("t2");

    // Backpressure: BG2, zc=64, e=640 with toggling then random ready.
    pat_mode   = 0;
    ready_mode = 1;
    for (int i = 0; i < 10; i++) exp_beat(i, 64, i == 9);
    start_job(LDPC_pkg::BG2, 64, 640);
    wait_done("t3a");
    ready_mode = 2;
    for (int i = 0; i < 10; i++) exp_beat(i, 64, i == 9);
    start_job(LDPC_pkg::BG2, 64, 640);
    wait_done("t3b");

    // Budget cap: BG2, zc=2, e=1000 -> 42 beats of 2 bits.
    for (int i = 0; i < 42; i++) exp_beat(i, 2, i == 41);
    start_job(LDPC_pkg::BG2, 2, 1000);
    wait_done("t4");

    // Zero budget and zero lifting size: done pulse only, no reads.
    ready_mode = 0;
    zero_job   = 1'b1;
    start_job(LDPC_pkg::BG1, 384, 0);
    @(negedge clk);
    chk("t5_done_T", CW'(done), CW'(0));
    @(negedge clk);
    chk("t5_done_T1", CW'(done), CW'(1));
    chk("t5_busy_T1", CW'(busy), CW'(0));
    @(negedge clk);
    chk("t5_done_T2", CW'(done), CW'(0));
    start_job(LDPC_pkg::BG2, 0, 1000);
    @(negedge clk);
    @(negedge clk);
    chk("t5z_done_T1", CW'(done), CW'(1));
    @(negedge clk);
    chk("t5z_done_T2", CW'(done), CW'(0));
    chk("t5z_busy_T2", CW'(busy), CW'(0));
    repeat (3) @(negedge clk);
    zero_job = 1'b0;

    // Reset after two beats of a 10-beat job, then a full job from address 0.
    for (int i = 0; i < 10; i++) exp_beat(i, 64, i == 9);
    base = acc_count;
    start_job(LDPC_pkg::BG2, 64, 640);
    n = 0;
    while (acc_count < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) fail("t6_two_beats_timeout");
    #1;
    reset_n         = 1'b0;
    cw_vector_valid = 1'b0;
    beat_q.delete();
    addr_q.delete();
    last_acc_q = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) exp_beat(i, 64, i == 9);
    start_job(LDPC_pkg::BG2, 64, 640);
    wait_done("t6_after");

    repeat (3) @(negedge clk);
    chk("final_addr_left", CW'(addr_q.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_parity_readout.md
# ldpc_parity_readout

Downstream consumer of `LDPC_encoder` that drains the finished parity blocks once `cw_vector_valid` rises. It drives the encoder's `parity_out_address` / `parity_out_rd_en` port and absorbs the 1-cycle read latency in a 2-entry skid FIFO. It emits one Zc-wide parity block per beat on a valid/ready stream, truncating the final block so that exactly `e_parity` parity bits leave the block, as the rate-matching bit-selection front end requires.

## Interface
Parameters:
- `MAX_ZC`, 384, width of one parity block word
- `ADDR_W`, 9, parity memory address width
- `E_W`, 16, width of the parity bit budget
- `BG1_PARITY_BLOCKS`, 46, parity block count for BG1
- `BG2_PARITY_BLOCKS`, 42, parity block count for BG2

Ports:
- `clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `cw_vector_valid` in 1: encoder codeword complete; level, rising edge starts a job
- `bg` in `bg_t`: base graph (BG1/BG2), sampled at start
- `zc` in 9: lifting size, sampled at start
- `e_parity` in E_W: parity bits to emit, sampled at start
- `parity_out_address` out ADDR_W: block index to read
- `parity_out_rd_en` out 1: read strobe; data is on `parity_out` the next cycle
- `parity_out` in MAX_ZC: parity block; bits [zc-1:0] are valid
- `pb_data` out MAX_ZC: output block; bits at and above `pb_len` are forced to 0
- `pb_len` out 9: valid bits in `pb_data` (1..zc)
- `pb_valid` out 1: beat valid
- `pb_last` out 1: final beat of the job
- `pb_ready` in 1: downstream accept
- `busy` out 1: job in progress
- `done` out 1: one-cycle pulse when the last beat is accepted

## Operation
- States: IDLE, READ, DRAIN.
- **IDLE**
  - A rising edge of `cw_vector_valid` latches `bg`, `zc` and `e_parity`.
  - `blk_max` = BG1_PARITY_BLOCKS or BG2_PARITY_BLOCKS, selected by `bg`.
  - If `e_parity == 0` or `zc == 0`: pulse `done` the next cycle and stay in IDLE. No reads are issued.
  - Otherwise go to READ.
- **READ**
  - Issue `rd_en` at address `rd_idx` whenever free FIFO entries minus in-flight reads is at least 1.
  - `rd_idx` starts at 0.
  - A parallel bit counter `rd_rem` starts at `e_parity` and is decremented by `zc` per issued read.
  - The tag captured with each read is `len = min(zc, rd_rem)` and `last = (rd_rem <= zc) || (rd_idx == blk_max-1)`.
  - After issuing the `last` read, go to DRAIN.
- **DRAIN**
  - Wait until the FIFO is empty and there is no read in flight, i.e. the last beat has been accepted.
  - Pulse `done`, then return to IDLE.
- **FIFO**
  - 2 entries of {data masked to len, len, last}.
  - A write happens the cycle after `rd_en`.
  - Head drives `pb_*`; pop when `pb_valid && pb_ready`.
  - Simultaneous push and pop is allowed when full.
- Budget overflow: if `e_parity > blk_max*zc`, exactly `blk_max` blocks are sent, each of length `zc`, and the last beat has `pb_len = zc`.
- Arithmetic: `rd_rem` is E_W wide, unsigned, and never underflows (len is taken as min). Address wrap cannot occur because `blk_max` is at most 46.
- `cw_vector_valid` edges seen while `busy` are ignored. The edge detector still tracks the level.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - `parity_out_rd_en` 0, `parity_out_address` 0.
  - `pb_valid` 0, `pb_last` 0, `pb_len` 0, `pb_data` 0.
  - `busy` 0, `done` 0, FIFO empty, state IDLE.
- Start edge sampled in cycle T: first `rd_en` (address 0) in T+1, FIFO write in T+2, `pb_valid` high in T+3.
- With `pb_ready` held high: one beat per cycle, no bubbles.
- `pb_*` hold stable while `pb_valid && !pb_ready`.
- `rd_en` must never be issued when it could overflow the FIFO. The full-credit check counts the in-flight read.
- `done` is asserted in the cycle after the accept of the `pb_last` beat.
- Reset mid-job: everything returns to reset values immediately; in-flight data is discarded.

## Structure
- `LDPC_pkg` holds:
  - `bg_t` (BG1/BG2, shared with the encoder)
  - `BG1_PARITY_BLOCKS`, `BG2_PARITY_BLOCKS`
  - `MAX_ZC`
  - the readout state enum `pr_state_t`
- One sub-module: `ldpc_pb_skid_fifo`, a 2-deep, MAX_ZC+10 bit wide FIFO with full/empty and count outputs.
- Masking to `pb_len` is done before the FIFO write.

## Test plan
- BG1, zc=384, e=1000, ready=1 → reads at addresses 0,1,2; `pb_len` 384,384,232; `pb_last` on the 3rd beat; `done` 1 cycle after it; first `pb_valid` at T+3.
- Masking: `parity_out` all ones, final len 232 → `pb_data[383:232]` = 0 and `[231:0]` all ones.
- Backpressure: BG2, zc=64, e=640, `pb_ready` toggled 1-0 and random → 10 beats in address order, none lost or duplicated, `rd_en` stalls, FIFO never overflows.
- Budget cap: BG2, zc=2, e=1000 → exactly 42 reads (addresses 0..41), every `pb_len` = 2, `pb_last` on beat 42.
- e=0 → no `rd_en`, `done` pulse 1 cycle after the start edge. A second `cw_vector_valid` edge while busy → ignored.
- Reset asserted after 2 beats of a 10-beat job → all outputs at reset values. A new start after reset completes a full job from address 0.
